// File: rtl/adaptive_route_lock_pkg.sv
// Shared types and helpers for the mesh router input-side route lock.
// Pure definitions: no logic, no latency.
// No flow control here; the route selector and top consume these items.
package adaptive_route_lock_pkg;

    // Two-state wormhole lock: waiting for a head beat, or bound to one output.
    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } route_state_t;

    // Bit positions of the mesh directions inside the productive mask. The
    // same offsets, added to LOCAL_PORTS, give the output channel index.
    localparam int DIR_N     = 0;
    localparam int DIR_E     = 1;
    localparam int DIR_S     = 2;
    localparam int DIR_W     = 3;
    localparam int MESH_DIRS = 4;

    // Channel index of a mesh direction: local ports come first, then N, E, S, W.
    function automatic int ch_idx(input int local_ports, input int dir);
        return local_ports + dir;
    endfunction

    // $clog2 that never returns zero, so single-entry ranges still get a bit.
    function automatic int width_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Directions that bring a packet closer to (tx, ty) from router (rx, ry).
    // North is decreasing Y, east is increasing X.
    function automatic logic [MESH_DIRS-1:0] xy_productive(input int tx, input int ty,
                                                           input int rx, input int ry);
        logic [MESH_DIRS-1:0] mask;
        mask        = '0;
        mask[DIR_N] = (ty < ry);
        mask[DIR_E] = (tx > rx);
        mask[DIR_S] = (ty > ry);
        mask[DIR_W] = (tx < rx);
        return mask;
    endfunction

endpackage

// File: rtl/adaptive_route_lock_if.sv
// AXI-Stream style beat bundle shared by the router input buffer and crossbar.
// Wires only: zero latency.
// Standard valid/ready: a beat moves when TVALID and TREADY are both high.
interface axis_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int DEST_WIDTH = 4,
    parameter int USER_WIDTH = 4
);
    logic                  TVALID;
    logic                  TREADY;
    logic                  TLAST;
    logic [DATA_WIDTH-1:0] TDATA;
    logic [ID_WIDTH-1:0]   TID;
    logic [DEST_WIDTH-1:0] TDEST;
    logic [USER_WIDTH-1:0] TUSER;

    modport m (
        output TVALID, TLAST, TDATA, TID, TDEST, TUSER,
        input  TREADY
    );

    modport s (
        input  TVALID, TLAST, TDATA, TID, TDEST, TUSER,
        output TREADY
    );
endinterface

// File: rtl/adaptive_route_lock_route_select.sv
// Picks the output channel for a head beat (local, XY, or minimal-adaptive with ADAPTIVE_ROUTE_EN).
// Combinational: decision is registered by the caller.
// With ADAPTIVE_ROUTE_EN, o_lock drops when both productive directions are stalled.
module adaptive_route_lock_route_select
    import adaptive_route_lock_pkg::*;
#(
    parameter int LOCAL_PORTS    = 1,
    parameter int ROUTER_X       = 0,
    parameter int ROUTER_Y       = 0,
    parameter int X_WIDTH        = 2,
    parameter int Y_WIDTH        = 2,
    parameter int LOC_WIDTH      = 1,
    parameter int SEL_WIDTH      = 3,
    parameter int CHANNEL_NUMBER = 5
) (
    input  logic [X_WIDTH-1:0]        i_target_x,
    input  logic [Y_WIDTH-1:0]        i_target_y,
    input  logic [LOC_WIDTH-1:0]      i_target_local,
    input  logic [CHANNEL_NUMBER-1:0] i_out_rdy,
    input  logic                      i_rr,
    output logic [SEL_WIDTH-1:0]      o_sel,
    output logic                      o_lock,
    output logic                      o_err,
    output logic                      o_tie
);

    localparam int CH_N = ch_idx(LOCAL_PORTS, DIR_N);
    localparam int CH_E = ch_idx(LOCAL_PORTS, DIR_E);
    localparam int CH_S = ch_idx(LOCAL_PORTS, DIR_S);
    localparam int CH_W = ch_idx(LOCAL_PORTS, DIR_W);

    logic [MESH_DIRS-1:0] w_mask;
    logic                 w_x_vld;
    logic                 w_y_vld;
    logic                 w_loc_ok;
    logic [SEL_WIDTH-1:0] w_x_ch;
    logic [SEL_WIDTH-1:0] w_y_ch;
    logic [SEL_WIDTH-1:0] w_loc_ch;

    // Productive directions and the single candidate channel on each axis.
    always_comb begin
        w_mask   = xy_productive(int'(i_target_x), int'(i_target_y), ROUTER_X, ROUTER_Y);
        w_x_vld  = w_mask[DIR_E] | w_mask[DIR_W];
        w_y_vld  = w_mask[DIR_N] | w_mask[DIR_S];
        w_x_ch   = w_mask[DIR_E] ? SEL_WIDTH'(CH_E) : SEL_WIDTH'(CH_W);
        w_y_ch   = w_mask[DIR_N] ? SEL_WIDTH'(CH_N) : SEL_WIDTH'(CH_S);
        w_loc_ok = (int'(i_target_local) < LOCAL_PORTS);
        w_loc_ch = w_loc_ok ? SEL_WIDTH'(i_target_local) : '0;
    end

`ifdef ADAPTIVE_ROUTE_EN
    logic w_x_rdy;
    logic w_y_rdy;
    assign w_x_rdy = i_out_rdy[w_x_ch];
    assign w_y_rdy = i_out_rdy[w_y_ch];
`else
    // Deterministic XY never looks at downstream readiness or the tie-break bit.
    logic w_unused_adaptive;
    assign w_unused_adaptive = ^{i_out_rdy, i_rr};
`endif

    // Final choice: a corner turn is where adaptive routing gets a say.
    always_comb begin
        o_sel  = w_loc_ch;
        o_lock = 1'b1;
        o_err  = 1'b0;
        o_tie  = 1'b0;
        if (w_x_vld && w_y_vld) begin
`ifdef ADAPTIVE_ROUTE_EN
            if (w_x_rdy && w_y_rdy) begin
                o_tie = 1'b1;
                o_sel = i_rr ? w_y_ch : w_x_ch;
            end else if (w_x_rdy) begin
                o_sel = w_x_ch;
            end else if (w_y_rdy) begin
                o_sel = w_y_ch;
            end else begin
                o_lock = 1'b0;
            end
`else
            o_sel = w_x_ch;
`endif
        end else if (w_x_vld) begin
            o_sel = w_x_ch;
        end else if (w_y_vld) begin
            o_sel = w_y_ch;
        end else begin
            o_err = !w_loc_ok;
        end
    end

endmodule

// File: rtl/axis_if_demux.sv
// Steers one stream to one of CHANNEL_NUMBER outputs selected by ctrl.
// Combinational: zero latency, payload fanned out to every output.
// Upstream TREADY is the selected output's TREADY gated by hit; TVALID never feeds back.
module axis_if_demux #(
    parameter int CHANNEL_NUMBER = 5,
    parameter int SEL_WIDTH      = 3
) (
    input  logic                 hit,
    input  logic [SEL_WIDTH-1:0] ctrl,
    axis_if.s                    s,
    axis_if.m                    m [CHANNEL_NUMBER]
);

    logic [CHANNEL_NUMBER-1:0] w_rdy;

    for (genvar i = 0; i < CHANNEL_NUMBER; i++) begin : g_ch
        assign m[i].TVALID = hit && (ctrl == SEL_WIDTH'(i)) && s.TVALID;
        assign m[i].TLAST  = s.TLAST;
        assign m[i].TDATA  = s.TDATA;
        assign m[i].TID    = s.TID;
        assign m[i].TDEST  = s.TDEST;
        assign m[i].TUSER  = s.TUSER;
        assign w_rdy[i]    = m[i].TREADY;
    end

    assign s.TREADY = hit && w_rdy[ctrl];

endmodule

// File: rtl/adaptive_route_lock.sv
// Per-input route lock: picks an output on the head beat, holds it until TLAST (build option ADAPTIVE_ROUTE_EN).
// Lock costs one IDLE cycle per packet; LOCKED beats pass with zero added latency.
// in.TREADY follows the locked output's TREADY; nothing is accepted while IDLE.
module adaptive_route_lock
    import adaptive_route_lock_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ID_WIDTH      = 4,
    parameter int DEST_WIDTH    = 4,
    parameter int USER_WIDTH    = 4,
    parameter int LOCAL_PORTS   = 1,
    parameter int MAX_ROUTERS_X = 4,
    parameter int MAX_ROUTERS_Y = 4,
    parameter int ROUTER_X      = 0,
    parameter int ROUTER_Y      = 0,
    parameter int CNT_WIDTH     = 16,
    localparam int CHANNEL_NUMBER      = MESH_DIRS + LOCAL_PORTS,
    localparam int MAX_ROUTERS_X_WIDTH = width_min1(MAX_ROUTERS_X),
    localparam int MAX_ROUTERS_Y_WIDTH = width_min1(MAX_ROUTERS_Y),
    localparam int LOCAL_WIDTH         = width_min1(LOCAL_PORTS)
) (
    input  logic                           clk,
    input  logic                           rst,
    axis_if.s                              in,
    axis_if.m                              out [CHANNEL_NUMBER],
    input  logic [MAX_ROUTERS_X_WIDTH-1:0] target_x,
    input  logic [MAX_ROUTERS_Y_WIDTH-1:0] target_y,
    input  logic [LOCAL_WIDTH-1:0]         target_local,
    output logic                           route_err,
    output logic [CNT_WIDTH-1:0]           pkt_count
);

    localparam int SEL_WIDTH = $clog2(CHANNEL_NUMBER);

    // Stream widths live on the interface instances; the parameters stay so
    // every router port is instantiated with one uniform parameter list.
    localparam int STREAM_WIDTH_UNUSED = DATA_WIDTH + ID_WIDTH + DEST_WIDTH + USER_WIDTH;

    route_state_t          r_state;
    route_state_t          w_state_nxt;
    logic [SEL_WIDTH-1:0]  r_sel;
    logic [SEL_WIDTH-1:0]  w_sel_nxt;
    logic                  r_rr;
    logic                  w_rr_nxt;
    logic                  r_route_err;
    logic                  w_err_nxt;
    logic [CNT_WIDTH-1:0]  r_pkt_count;
    logic [CNT_WIDTH-1:0]  w_cnt_nxt;

    logic [CHANNEL_NUMBER-1:0] w_out_rdy;
    logic [SEL_WIDTH-1:0]      w_rs_sel;
    logic                      w_rs_lock;
    logic                      w_rs_err;
    logic                      w_rs_tie;
    logic                      w_hit;
    logic                      w_last_hs;

    for (genvar i = 0; i < CHANNEL_NUMBER; i++) begin : g_rdy
        assign w_out_rdy[i] = out[i].TREADY;
    end

    adaptive_route_lock_route_select #(
        .LOCAL_PORTS    (LOCAL_PORTS),
        .ROUTER_X       (ROUTER_X),
        .ROUTER_Y       (ROUTER_Y),
        .X_WIDTH        (MAX_ROUTERS_X_WIDTH),
        .Y_WIDTH        (MAX_ROUTERS_Y_WIDTH),
        .LOC_WIDTH      (LOCAL_WIDTH),
        .SEL_WIDTH      (SEL_WIDTH),
        .CHANNEL_NUMBER (CHANNEL_NUMBER)
    ) u_route_select (
        .i_target_x     (target_x),
        .i_target_y     (target_y),
        .i_target_local (target_local),
        .i_out_rdy      (w_out_rdy),
        .i_rr           (r_rr),
        .o_sel          (w_rs_sel),
        .o_lock         (w_rs_lock),
        .o_err          (w_rs_err),
        .o_tie          (w_rs_tie)
    );

    assign w_hit     = (r_state == LOCKED);
    assign w_last_hs = w_hit && in.TVALID && w_out_rdy[r_sel] && in.TLAST;

    // Next-state: lock on a routable head beat, release on the TLAST handshake.
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_rr_nxt    = r_rr;
        w_cnt_nxt   = r_pkt_count;
        w_err_nxt   = 1'b0;
        case (r_state)
            IDLE: begin
                if (in.TVALID && w_rs_lock) begin
                    w_state_nxt = LOCKED;
                    w_sel_nxt   = w_rs_sel;
                    w_err_nxt   = w_rs_err;
                    if (w_rs_tie) begin
                        w_rr_nxt = ~r_rr;
                    end
                end
            end
            LOCKED: begin
                if (w_last_hs) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = r_pkt_count + CNT_WIDTH'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Lock state, selected channel, tie-break bit, error pulse and packet counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_sel       <= '0;
            r_rr        <= 1'b0;
            r_route_err <= 1'b0;
            r_pkt_count <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_sel       <= w_sel_nxt;
            r_rr        <= w_rr_nxt;
            r_route_err <= w_err_nxt;
            r_pkt_count <= w_cnt_nxt;
        end
    end

    axis_if_demux #(
        .CHANNEL_NUMBER (CHANNEL_NUMBER),
        .SEL_WIDTH      (SEL_WIDTH)
    ) u_demux (
        .hit  (w_hit),
        .ctrl (r_sel),
        .s    (in),
        .m    (out)
    );

    assign route_err = r_route_err;
    assign pkt_count = r_pkt_count;

endmodule

// File: tb/tb_adaptive_route_lock.sv
// Bench for adaptive_route_lock: router (1,1) in a 4x4 mesh, three local ports, 2-bit counter.
// Every cycle of every packet is compared against a reference route/lock model.
// Downstream readiness is forced, stalled or randomized per step.
`timescale 1ns/1ps
module tb_adaptive_route_lock;

    localparam int LP     = 3;
    localparam int CH     = LP + 4;
    localparam int RX     = 1;
    localparam int RY     = 1;
    localparam int CNTW   = 2;
    localparam int CH_N   = LP;
    localparam int CH_E   = LP + 1;
    localparam int CH_S   = LP + 2;
    localparam int CH_W   = LP + 3;
    localparam int BUDGET = 200;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    axis_if #(.DATA_WIDTH(32), .ID_WIDTH(4), .DEST_WIDTH(4), .USER_WIDTH(4)) in_if ();
    axis_if #(.DATA_WIDTH(32), .ID_WIDTH(4), .DEST_WIDTH(4), .USER_WIDTH(4)) out_if [CH] ();

    logic [1:0]      tgt_x;
    logic [1:0]      tgt_y;
    logic [1:0]      tgt_l;
    logic            route_err;
    logic [CNTW-1:0] pkt_count;

    logic [CH-1:0] tb_rdy;
    logic [CH-1:0] mon_vld;
    logic [CH-1:0] mon_last;
    logic [31:0]   mon_dat  [CH];
    logic [3:0]    mon_user [CH];

    for (genvar g = 0; g < CH; g++) begin : g_mon
        assign out_if[g].TREADY = tb_rdy[g];
        assign mon_vld[g]       = out_if[g].TVALID;
        assign mon_last[g]      = out_if[g].TLAST;
        assign mon_dat[g]       = out_if[g].TDATA;
        assign mon_user[g]      = out_if[g].TUSER;
    end

    adaptive_route_lock #(
        .DATA_WIDTH(32), .ID_WIDTH(4), .DEST_WIDTH(4), .USER_WIDTH(4),
        .LOCAL_PORTS(LP), .MAX_ROUTERS_X(4), .MAX_ROUTERS_Y(4),
        .ROUTER_X(RX), .ROUTER_Y(RY), .CNT_WIDTH(CNTW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in           (in_if),
        .out          (out_if),
        .target_x     (tgt_x),
        .target_y     (tgt_y),
        .target_local (tgt_l),
        .route_err    (route_err),
        .pkt_count    (pkt_count)
    );

    int            n_checks = 0;
    int            n_pass   = 0;
    int            n_fail   = 0;
    int            exp_cnt  = 0;
    bit            exp_rr   = 1'b0;
    int            rdy_mode = 0;
    int            stall_n  = 0;
    logic [CH-1:0] rdy_fixed;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Readiness pattern: 0 all ready, 1 random, 2 fixed pattern for stall_n cycles then all ready.
    task automatic set_rdy(input int cyc);
        case (rdy_mode)
            1:       tb_rdy = CH'($urandom);
            2:       tb_rdy = (cyc < stall_n) ? rdy_fixed : '1;
            default: tb_rdy = '1;
        endcase
    endtask

    // Reference routing rule, worked from coordinate differences.
    function automatic int exp_route(input int tx, input int ty, input int tl,
                                     input logic [CH-1:0] rdy, input bit rr,
                                     output bit lock, output bit err, output bit tie);
        int dx;
        int dy;
        int xch;
        int ych;
        dx   = tx - RX;
        dy   = ty - RY;
        xch  = (dx > 0) ? CH_E : CH_W;
        ych  = (dy < 0) ? CH_N : CH_S;
        lock = 1'b1;
        err  = 1'b0;
        tie  = 1'b0;
        if (dx == 0 && dy == 0) begin
            if (tl < LP) return tl;
            err = 1'b1;
            return 0;
        end
        if (dx == 0) return ych;
        if (dy == 0) return xch;
`ifdef ADAPTIVE_ROUTE_EN
        if (rdy[xch] && rdy[ych]) begin
            tie = 1'b1;
            return rr ? ych : xch;
        end
        if (rdy[xch]) return xch;
        if (rdy[ych]) return ych;
        lock = 1'b0;
        return 0;
`else
        return xch;
`endif
    endfunction

    // Sends one packet of n beats and checks every cycle until its TLAST handshake.
    // abort_at > 0 asserts rst after that many beats have transferred.
    task automatic run_pkt(input int tx, input int ty, input int tl, input int n, input int abort_at);
        int            beat;
        int            cyc;
        int            ch;
        bit            locked;
        bit            err_pend;
        bit            lk;
        bit            er;
        bit            ti;
        bit            hs;
        logic [31:0]   cur_dat;
        logic [3:0]    cur_user;
        logic          cur_last;
        logic [CH-1:0] onehot;
        beat     = 0;
        cyc      = 0;
        ch       = 0;
        locked   = 1'b0;
        err_pend = 1'b0;
        tgt_x    = 2'(tx);
        tgt_y    = 2'(ty);
        tgt_l    = 2'(tl);
        cur_dat  = $urandom;
        cur_user = 4'($urandom);
        cur_last = (n == 1);
        in_if.TVALID = 1'b1;
        in_if.TDATA  = cur_dat;
        in_if.TUSER  = cur_user;
        in_if.TID    = 4'($urandom);
        in_if.TDEST  = 4'($urandom);
        in_if.TLAST  = cur_last;
        set_rdy(0);
        forever begin
            @(negedge clk);
            check("route_err", route_err, err_pend);
            check("pkt_count", pkt_count, exp_cnt);
            hs = 1'b0;
            lk = 1'b0;
            er = 1'b0;
            ti = 1'b0;
            if (!locked) begin
                check("idle_out_vld", mon_vld, '0);
                check("idle_in_rdy", in_if.TREADY, 1'b0);
                ch = exp_route(tx, ty, tl, tb_rdy, exp_rr, lk, er, ti);
            end else begin
                onehot     = '0;
                onehot[ch] = 1'b1;
                check("lock_out_vld", mon_vld, onehot);
                check("lock_dat", mon_dat[ch], cur_dat);
                check("lock_user", mon_user[ch], cur_user);
                check("lock_last", mon_last[ch], cur_last);
                check("lock_in_rdy", in_if.TREADY, tb_rdy[ch]);
                hs = tb_rdy[ch];
            end
            @(posedge clk);
            #1;
            err_pend = 1'b0;
            if (!locked && lk) begin
                locked   = 1'b1;
                err_pend = er;
                if (ti) exp_rr = !exp_rr;
            end
            if (hs) begin
                beat++;
                if (beat == n) begin
                    exp_cnt      = (exp_cnt + 1) % (1 << CNTW);
                    in_if.TVALID = 1'b0;
                    return;
                end
                cur_dat     = $urandom;
                cur_user    = 4'($urandom);
                cur_last    = (beat == n - 1);
                in_if.TDATA = cur_dat;
                in_if.TUSER = cur_user;
                in_if.TLAST = cur_last;
            end
            if (locked) begin
                // Coordinates wander after the lock; the route must not follow them.
                tgt_x = 2'($urandom);
                tgt_y = 2'($urandom);
                tgt_l = 2'($urandom);
            end
            if (abort_at != 0 && beat == abort_at) begin
                rst = 1'b1;
                @(posedge clk);
                #1;
                @(negedge clk);
                check("rst_out_vld", mon_vld, '0);
                check("rst_in_rdy", in_if.TREADY, 1'b0);
                check("rst_pkt_count", pkt_count, '0);
                check("rst_route_err", route_err, 1'b0);
                @(posedge clk);
                #1;
                rst          = 1'b0;
                in_if.TVALID = 1'b0;
                exp_cnt      = 0;
                exp_rr       = 1'b0;
                return;
            end
            cyc++;
            if (cyc >= BUDGET) begin
                n_checks++;
                n_fail++;
                $error("FAIL pkt_timeout: cycles %0d reached limit %0d", cyc, BUDGET);
                in_if.TVALID = 1'b0;
                return;
            end
            set_rdy(cyc);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        in_if.TVALID = 1'b0;
        in_if.TDATA  = '0;
        in_if.TLAST  = 1'b0;
        in_if.TID    = '0;
        in_if.TDEST  = '0;
        in_if.TUSER  = '0;
        tgt_x        = '0;
        tgt_y        = '0;
        tgt_l        = '0;
        tb_rdy       = '1;
        rdy_fixed    = '1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset_out_vld", mon_vld, '0);
        check("reset_in_rdy", in_if.TREADY, 1'b0);
        check("reset_pkt_count", pkt_count, '0);
        check("reset_route_err", route_err, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Local delivery on port 0, all outputs ready.
        rdy_mode = 0;
        run_pkt(1, 1, 0, 3, 0);

        // Corner turn toward (3,0) with east stalled for the first cycles.
        rdy_mode        = 2;
        stall_n         = 5;
        rdy_fixed       = '1;
        rdy_fixed[CH_E] = 1'b0;
        run_pkt(3, 0, 0, 3, 0);

        // Same corner turn twice with everything ready: tie-break alternates.
        rdy_mode = 0;
        run_pkt(3, 0, 0, 2, 0);
        run_pkt(3, 0, 0, 2, 0);

        // Four packets since reset: the 2-bit counter has wrapped.
        @(negedge clk);
        check("cnt_wrap", pkt_count, '0);
        @(posedge clk);
        #1;

        // Local index beyond the port count falls back to port 0 with an error pulse.
        run_pkt(1, 1, 3, 2, 0);
        run_pkt(1, 1, 2, 1, 0);

        // Reset after two beats of five, then a fresh head routes normally.
        run_pkt(0, 3, 0, 5, 2);
        run_pkt(2, 2, 0, 2, 0);
        run_pkt(1, 0, 0, 1, 0);

        // Randomized targets, lengths and downstream readiness.
        rdy_mode = 1;
        for (int k = 0; k < 40; k++) begin
            run_pkt(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), int'($urandom_range(1, 4)), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/adaptive_route_lock.md
# adaptive_route_lock

- Per-input route computation and packet lock for the mesh router.
- Decides an output channel from the head beat's target coordinates, then holds that channel for the whole packet until the TLAST handshake (wormhole).
- Selects between deterministic XY routing and minimal-adaptive routing.
- Sits between each router input buffer and the crossbar; reuses `axis_if_demux` for the data path.

## Interface
- `DATA_WIDTH`, 32: TDATA width
- `ID_WIDTH` / `DEST_WIDTH` / `USER_WIDTH`, 4: sideband widths; absent under `USE_LIGHT_STREAM`
- `LOCAL_PORTS`, 1: local ports, ≥1; `CHANNEL_NUMBER` = 4 + `LOCAL_PORTS`
- `MAX_ROUTERS_X` / `MAX_ROUTERS_Y`, 4: mesh size; widths are `$clog2` of each
- `ROUTER_X` / `ROUTER_Y`, 0: this router's coordinates
- `CNT_WIDTH`, 16: packet counter width
- `clk`  in  1: single clock
- `rst`  in  1: synchronous, active-high reset
- `in`  axis_if.s: packet stream from the input buffer
- `out[CHANNEL_NUMBER]`  axis_if.m: channel 0..`LOCAL_PORTS`-1 local; then N, E, S, W
- `target_x`  in  `MAX_ROUTERS_X_WIDTH`: head-beat destination X
- `target_y`  in  `MAX_ROUTERS_Y_WIDTH`: head-beat destination Y
- `target_local`  in  `$clog2(LOCAL_PORTS)` (min 1): head-beat local port index
- `route_err`  out  1: one-cycle pulse on lock when `target_local` ≥ `LOCAL_PORTS`
- `pkt_count`  out  `CNT_WIDTH`: packets completed; wraps

## Operation
- **FSM states:** IDLE, LOCKED.
- **IDLE:**
  - `in.TREADY`=0 and every `out[i].TVALID`=0.
  - When `in.TVALID`=1, evaluate the head beat:
    - Local hit (X and Y equal): port `target_local`. If out of range, use port 0 and pulse `route_err`.
    - Productive set: N if `target_y`<`ROUTER_Y`; S if >. E if `target_x`>`ROUTER_X`; W if <.
  - Register the chosen channel into `sel`, go to LOCKED.
- **LOCKED:**
  - `out[sel]` mirrors all `in` fields including TVALID; `in.TREADY` = `out[sel].TREADY`.
  - Other outputs have TVALID=0.
  - On the TLAST handshake (`in.TVALID`&`in.TREADY`&`in.TLAST`): return to IDLE and increment `pkt_count` mod 2^`CNT_WIDTH`.
- **Coordinates:** `target_*` are sampled only in IDLE. Changes during LOCKED are ignored.
- **Single-beat packet:** IDLE→LOCKED→IDLE, one handshake.
- **Back-to-back packets:** every packet costs one IDLE cycle.
- **Reset:** from any state, including mid-packet:
  - Go to IDLE; `sel`=0, `rr`=0, `pkt_count`=0, `route_err`=0.
  - All `out[i].TVALID`=0 and `in.TREADY`=0 in the cycle after `rst` is sampled high.
  - A truncated packet is the upstream's responsibility.

## Timing
- Lock decision: registered. First beat can transfer 1 cycle after `in.TVALID` first seen in IDLE (earliest).
- LOCKED throughput: 1 beat/cycle, zero added latency; TREADY/TVALID paths are combinational through `sel`.
- `route_err` asserted in the same cycle as the IDLE→LOCKED transition register update; visible for the first LOCKED cycle only.
- `pkt_count` updates the cycle after the TLAST handshake.
- The router must not combinationally make `out[i].TREADY` depend on `out[i].TVALID`.

## Configuration
- Macro: `ADAPTIVE_ROUTE_EN`.
- **Undefined (deterministic XY):**
  - Choose X direction (E/W) if non-empty, else Y (N/S), else local.
  - Lock immediately regardless of TREADY.
- **Defined (minimal-adaptive):**
  - If both X and Y directions are productive, choose the one whose TREADY=1.
  - If both are ready, choose by 1-bit round-robin `rr` (0→X, 1→Y); toggle `rr` after each such tie.
  - If neither is ready, stay in IDLE and re-evaluate next cycle.
  - A single productive direction or local locks regardless of TREADY.

## Structure
- Shared package `router_pkg`:
  - channel index constants `CH_N`, `CH_E`, `CH_S`, `CH_W` relative to `LOCAL_PORTS`;
  - state enum `route_state_t {IDLE, LOCKED}`;
  - function `xy_productive()` returning the 4-bit productive mask.
- Data path instantiates existing `axis_if_demux` with `hit` = (state==LOCKED), `ctrl` = `sel`.
- Natural sub-module: `route_select` (combinational candidate/tie-break logic, owns the macro).

## Test plan
- **Local delivery:** router (1,1), target (1,1), local 0, 3-beat packet, all ready → beats on `out[0]` only, cycles 1–3 after TVALID; `pkt_count`=1.
- **XY order, deterministic:** target (3,0) from (1,1), E stalled 4 cycles → locks E anyway; N never sees TVALID; packet completes after stall.
- **Adaptive, E not ready:** `ADAPTIVE_ROUTE_EN`, target (3,0), E.TREADY=0, N.TREADY=1 → locks N.
- **Adaptive, both ready:** `ADAPTIVE_ROUTE_EN`, both ready on two consecutive packets → first E, second N (`rr` toggles).
- **Reset mid-packet:** `rst` after beat 2 of 5 → next cycle all TVALID=0, `in.TREADY`=0, `pkt_count`=0. A new head routes fresh.
- **Bad local index:** `LOCAL_PORTS`=2, `target_local`=3 → `route_err` pulse 1 cycle, packet delivered on `out[0]`. `pkt_count` wraps 0xFFFF→0 after 65536 packets (force via `CNT_WIDTH`=2: 4 packets → 0).
